// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Fetch state encoding, reset PC default and PC arithmetic helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous {pc, inst} FIFO; pop is combinational on the head, push lands next cycle.
// No internal backpressure: callers must not push into a full buffer unless popping.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [31:0]   push_pc_i,
  input  logic [31:0]   push_inst_i,
  input  logic          pop_i,
  output logic [31:0]   head_pc_o,
  output logic [31:0]   head_inst_o,
  output logic [AW:0]   occ_o,
  output logic          empty_o
);

  logic [31:0] pc_q   [DEPTH];
  logic [31:0] inst_q [DEPTH];
  logic [AW:0] rd_q, rd_d;
  logic [AW:0] wr_q, wr_d;
  logic        full;
  logic        push_ok;
  logic        pop_ok;

  assign occ_o       = wr_q - rd_q;
  assign empty_o     = (occ_o == '0);
  assign full        = (occ_o == (AW+1)'(DEPTH));
  assign head_pc_o   = pc_q[rd_q[AW-1:0]];
  assign head_inst_o = inst_q[rd_q[AW-1:0]];

  // A pop frees the head slot in the same cycle, so a full buffer may still take a push.
  assign push_ok = push_i && !clear_i && (!full || pop_i);
  assign pop_ok  = pop_i && !clear_i && !empty_o;

  always_comb begin
    rd_d = rd_q;
    wr_d = wr_q;
    if (clear_i) begin
      rd_d = '0;
      wr_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_q[wr_q[AW-1:0]]   <= push_pc_i;
      inst_q[wr_q[AW-1:0]] <= push_inst_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order imem requests, buffered delivery, redirect with drop.
// Latency 2 cycles + memory latency; stall holds the buffer, credits stop requests when it is full.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_v,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_v,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_v,
  input  logic [31:0] redirect_pc,
  output logic        inst_v_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  localparam int AW = $clog2(BUF_DEPTH);
  // Back-to-back redirects can stack drops on top of live requests, so leave headroom.
  localparam int CW = AW + 6;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [AW:0]   ibuf_occ;
  logic          ibuf_empty;
  logic [31:0]   pcq_head_pc;
  logic [31:0]   pcq_inst_unused;
  logic [AW:0]   pcq_occ_unused;
  logic          pcq_empty_unused;
  logic [1:0]    redirect_lsb_unused;

  logic [CW-1:0] live_cnt;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_keep;

  assign redirect_lsb_unused = redirect_pc[1:0];

  // Dropped responses hold no buffer slot, so they do not consume credit.
  assign live_cnt  = out_q - drop_q + CW'(ibuf_occ);
  assign credit_ok = (live_cnt < CW'(BUF_DEPTH));

  assign imem_req_v    = !reset && (state_q != BOOT) && !redirect_v && credit_ok;
  assign imem_req_addr = fetch_pc_q;
  assign req_fire      = imem_req_v && imem_req_ready;

  assign rsp_keep = imem_rsp_v && (drop_q == '0) && !redirect_v;

  assign inst_v_o = !reset && !ibuf_empty && !stall && !redirect_v;

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_ibuf (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (redirect_v),
    .push_i      (rsp_keep),
    .push_pc_i   (pcq_head_pc),
    .push_inst_i (imem_rsp_data),
    .pop_i       (inst_v_o),
    .head_pc_o   (pc_o),
    .head_inst_o (inst_o),
    .occ_o       (ibuf_occ),
    .empty_o     (ibuf_empty)
  );

  // Holds PCs of live (non-dropped) requests only; a redirect wipes it as those become drops.
  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_pcq (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (redirect_v),
    .push_i      (req_fire),
    .push_pc_i   (fetch_pc_q),
    .push_inst_i ('0),
    .pop_i       (rsp_keep),
    .head_pc_o   (pcq_head_pc),
    .head_inst_o (pcq_inst_unused),
    .occ_o       (pcq_occ_unused),
    .empty_o     (pcq_empty_unused)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q + CW'(req_fire) - CW'(imem_rsp_v);
    drop_d     = drop_q;
    state_d    = state_q;

    if (redirect_v) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_d     = out_q - CW'(imem_rsp_v);
    end else begin
      if (req_fire) fetch_pc_d = next_word_pc(fetch_pc_q);
      if (imem_rsp_v && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end

    case (state_q)
      BOOT:    state_d = RUN;
      default: state_d = (drop_d != '0) ? FLUSH : RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  a_rsp_has_request: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_v |-> (out_q != '0));

  a_no_buffer_overflow: assert property (@(posedge clk) disable iff (reset)
    rsp_keep |-> (ibuf_occ < (AW+1)'(BUF_DEPTH)) || inst_v_o);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order imem model of configurable latency.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        imem_req_v;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_v;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_v;
  logic [31:0] redirect_pc;
  logic        inst_v_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_v     (imem_req_v),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_v     (imem_rsp_v),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect_v     (redirect_v),
    .redirect_pc    (redirect_pc),
    .inst_v_o       (inst_v_o),
    .inst_o         (inst_o),
    .pc_o           (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          mem_lat;
  int          acc_cnt;
  int          dlv_cnt;
  int          inst_bad = 0;
  int          first_dlv;
  int          idx;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] dq[$];
  logic        s_req_v;
  logic [31:0] s_req_addr;
  logic        s_inst_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  function automatic int seq_gaps(input int s);
    int bad = 0;
    for (int i = s + 1; i < dq.size(); i++)
      if (dq[i] !== dq[i-1] + 32'd4) bad++;
    return bad;
  endfunction

  // One clock cycle: drive memory response, sample outputs mid-cycle, update models.
  task automatic tick();
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      imem_rsp_v    = 1'b1;
      imem_rsp_data = word(mq_addr[0]);
    end else begin
      imem_rsp_v    = 1'b0;
      imem_rsp_data = '0;
    end
    #2;
    s_req_v    = imem_req_v;
    s_req_addr = imem_req_addr;
    s_inst_v   = inst_v_o;
    if (imem_rsp_v) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (imem_req_v && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + mem_lat);
      acc_cnt++;
    end
    if (inst_v_o) begin
      dq.push_back(pc_o);
      dlv_cnt++;
      if (inst_o !== word(pc_o)) inst_bad++;
      if (first_dlv < 0) first_dlv = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int lat);
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_v     = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_v     = 1'b0;
    imem_rsp_data  = '0;
    mem_lat        = lat;
    mq_addr.delete();
    mq_due.delete();
    dq.delete();
    first_dlv = -1;
    acc_cnt   = 0;
    dlv_cnt   = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_v", imem_req_v, 0);
    chk("rst_inst_v", inst_v_o, 0);
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    // Streaming from reset, 1-cycle memory
    do_reset(1);
    tick();
    chk("boot_no_req", s_req_v, 0);
    tick();
    chk("first_req_v", s_req_v, 1);
    chk("first_req_addr", s_req_addr, 32'h0);
    repeat (28) tick();
    chk("first_dlv_cycle", first_dlv, 3);
    chk("a_count", dq.size() >= 8, 1);
    for (int i = 0; i < 8; i++) chk("a_pc", dq[i], 32'(4 * i));

    // Stall for 5 cycles mid-stream
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_inst_v", s_inst_v, 0);
      chk("stall_credit", (acc_cnt - dlv_cnt) <= 2, 1);
    end
    stall = 1'b0;
    idx = dq.size();
    repeat (12) tick();
    chk("b_resumed", dq.size() > idx, 1);
    chk("b_seq_gaps", seq_gaps(0), 0);

    // Redirect while the buffer holds words and delivery is not stalled
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    chk("g_buffered", (acc_cnt - dlv_cnt - mq_addr.size()) != 0, 1);
    redirect_v  = 1'b1;
    redirect_pc = 32'h0000_0400;
    tick();
    chk("g_redir_inst_v", s_inst_v, 0);
    chk("g_redir_req_v", s_req_v, 0);
    redirect_v = 1'b0;
    idx = dq.size();
    repeat (15) tick();
    chk("g_first_pc", dq[idx], 32'h0000_0400);
    chk("g_seq_gaps", seq_gaps(idx), 0);

    // Redirect with two requests in flight, 3-cycle memory
    do_reset(3);
    repeat (3) tick();
    chk("c_inflight", mq_addr.size(), 2);
    redirect_v  = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    chk("c_redir_inst_v", s_inst_v, 0);
    chk("c_redir_req_v", s_req_v, 0);
    redirect_v = 1'b0;
    tick();
    chk("c_flush_req_v", s_req_v, 1);
    chk("c_flush_req_addr", s_req_addr, 32'h0000_0100);
    repeat (12) tick();
    chk("c_first_pc", dq[0], 32'h0000_0100);
    chk("c_seq_gaps", seq_gaps(0), 0);

    // Response arriving in the redirect cycle; unaligned target near wrap
    do_reset(3);
    repeat (4) tick();
    redirect_v  = 1'b1;
    redirect_pc = 32'hFFFF_FFFD;
    tick();
    chk("d_redir_inst_v", s_inst_v, 0);
    redirect_v = 1'b0;
    repeat (12) tick();
    chk("d_first_pc", dq[0], 32'hFFFF_FFFC);
    chk("d_wrap_pc", dq[1], 32'h0000_0000);

    // Second redirect during FLUSH
    do_reset(3);
    repeat (3) tick();
    redirect_v  = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect_v = 1'b0;
    tick();
    chk("e_req_0x100", s_req_addr, 32'h0000_0100);
    redirect_v  = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect_v = 1'b0;
    repeat (14) tick();
    chk("e_first_pc", dq[0], 32'h0000_0200);
    chk("e_seq_gaps", seq_gaps(0), 0);

    // Request channel not ready for 4 cycles
    do_reset(1);
    repeat (3) tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("f_addr_hold", s_req_addr, 32'h0000_0008);
    end
    chk("f_req_v_held", s_req_v, 1);
    imem_req_ready = 1'b1;
    repeat (15) tick();
    chk("f_count", dq.size() >= 6, 1);
    chk("f_first_pc", dq[0], 32'h0);
    chk("f_seq_gaps", seq_gaps(0), 0);

    chk("inst_matches_pc", inst_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
